// File: rtl/systolic_col_collector.sv
// Deskews bottom-row PE partial sums, accumulates them per row across K-passes, and queues finished rows.
// Latency NUM_COL cycles from the column-0 sample to out_valid; in_ready is advisory and rows arriving at a full FIFO are dropped (ovf_err).

// Row FIFO with combinational head; a push into a full FIFO is accepted only if the head pops in the same cycle.
module systolic_col_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    output logic             drop_o,
    output logic             head_vld_o,
    input  logic             head_rdy_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full, pop, wr_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full       = (cnt_q == CNT_W'(DEPTH));
    assign head_vld_o = (cnt_q != '0);
    assign pop        = head_vld_o && head_rdy_i;
    assign wr_en      = push_vld_i && (!full || pop);
    assign drop_o     = push_vld_i && full && !pop;
    assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !wr_en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_d;
        end
    end
endmodule

module systolic_col_collector #(
    parameter int NUM_COL    = 4,
    parameter int BW_ACCU    = 32,
    parameter int ACC_DEPTH  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic [$clog2(ACC_DEPTH)-1:0] in_row,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [NUM_COL*BW_ACCU-1:0]   col_data_in,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_COL*BW_ACCU-1:0]   out_data,
    output logic                         ovf_err
);
    localparam int ROW_W = $clog2(ACC_DEPTH);
    localparam int DAT_W = NUM_COL * BW_ACCU;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Stage 0 samples at the column-0 edge; stage NUM_COL-1 lines up with the deskewed data.
    logic [NUM_COL-1:0] vld_q, first_q, last_q;
    logic [ROW_W-1:0]   row_q [NUM_COL];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < NUM_COL; i++) row_q[i] <= '0;
        end else begin
            vld_q   <= {vld_q[NUM_COL-2:0], in_valid};
            first_q <= {first_q[NUM_COL-2:0], in_first};
            last_q  <= {last_q[NUM_COL-2:0], in_last};
            row_q[0] <= in_row;
            for (int i = 1; i < NUM_COL; i++) row_q[i] <= row_q[i-1];
        end
    end

    logic [DAT_W-1:0] algn_dat;

    for (genvar c = 0; c < NUM_COL; c++) begin : g_lane
        localparam int LEN = NUM_COL - c;
        logic [BW_ACCU-1:0] dly_q [LEN];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < LEN; i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= col_data_in[c*BW_ACCU +: BW_ACCU];
                for (int i = 1; i < LEN; i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign algn_dat[c*BW_ACCU +: BW_ACCU] = dly_q[LEN-1];
    end

    logic             a_vld, a_first, a_last;
    logic [ROW_W-1:0] a_row;
    logic [DAT_W-1:0] acc_q [ACC_DEPTH];
    logic [DAT_W-1:0] acc_rd, acc_d;

    assign a_vld   = vld_q[NUM_COL-1];
    assign a_first = first_q[NUM_COL-1];
    assign a_last  = last_q[NUM_COL-1];
    assign a_row   = row_q[NUM_COL-1];
    assign acc_rd  = acc_q[a_row];

    // Read-modify-write in one cycle, so a row may be hit on consecutive cycles.
    always_comb begin
        acc_d = algn_dat;
        if (!a_first) begin
            for (int c = 0; c < NUM_COL; c++) begin
                acc_d[c*BW_ACCU +: BW_ACCU] = acc_rd[c*BW_ACCU +: BW_ACCU] + algn_dat[c*BW_ACCU +: BW_ACCU];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ACC_DEPTH; r++) acc_q[r] <= '0;
        end else if (a_vld) begin
            acc_q[a_row] <= acc_d;
        end
    end

    logic             fifo_drop;
    logic [CNT_W-1:0] fifo_cnt;
    logic             ovf_q;

    systolic_col_fifo #(
        .WIDTH (DAT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_vld_i (a_vld && a_last),
        .push_dat_i (acc_d),
        .drop_o     (fifo_drop),
        .head_vld_o (out_valid),
        .head_rdy_i (out_ready),
        .head_dat_o (out_data),
        .count_o    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (fifo_drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
    // Keep room for up to NUM_COL rows already inside the deskew pipeline.
    assign in_ready = (fifo_cnt < CNT_W'(FIFO_DEPTH - NUM_COL));
endmodule
